// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: multi-lane push/pop,
// full flush, and branch-redirect flush that keeps a pending delay-slot entry.

module inst_queue_rd_lane #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 96,
   parameter int PTR_W   = 3,
   parameter int CNT_W   = 4,
   parameter int LANE    = 0
) (
   input  logic [DEPTH-1:0][ENTRY_W:0] mem,
   input  logic [PTR_W-1:0]            head,
   input  logic [CNT_W-1:0]            count,
   output logic                        valid,
   output logic [ENTRY_W-1:0]          data,
   output logic                        bd
);
   logic [PTR_W-1:0] idx;

   // bd is gated by valid so an empty queue never shows a stale delay-slot flag
   always_comb begin
      idx   = head + PTR_W'(LANE);
      valid = count > CNT_W'(LANE);
      data  = mem[idx][ENTRY_W:1];
      bd    = valid & mem[idx][0];
   end
endmodule

module inst_queue #(
   parameter int DEPTH     = 8,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int ENTRY_W   = 96
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [IN_WIDTH-1:0]                in_valid,
   input  logic [IN_WIDTH*ENTRY_W-1:0]        in_data,
   input  logic [IN_WIDTH-1:0]                in_bd,
   output logic                               in_allowin,
   output logic [OUT_WIDTH-1:0]               out_valid,
   output logic [OUT_WIDTH*ENTRY_W-1:0]       out_data,
   output logic [OUT_WIDTH-1:0]               out_bd,
   input  logic [$clog2(OUT_WIDTH+1)-1:0]     out_pop_cnt,
   input  logic                               flush,
   input  logic                               bpu_flush,
   output logic [$clog2(DEPTH+1)-1:0]         count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int POP_W = $clog2(OUT_WIDTH+1);
   localparam int NIN_W = $clog2(IN_WIDTH+1);

   // entry layout: {payload, bd}
   logic [DEPTH-1:0][ENTRY_W:0] mem_q;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                            push_en;
   logic [NIN_W-1:0]                n_push;
   logic [POP_W-1:0]                pop_eff;
   logic [PTR_W-1:0]                r_idx;
   logic                            retain;
   logic [IN_WIDTH-1:0]             wr_en;
   logic [IN_WIDTH-1:0][PTR_W-1:0]  wr_idx;
   logic [IN_WIDTH-1:0][ENTRY_W:0]  wr_ent;

   assign in_allowin = count_q <= CNT_W'(DEPTH - IN_WIDTH);
   assign count      = count_q;

   always_comb begin
      n_push = '0;
      for (int i = 0; i < IN_WIDTH; i++)
         n_push = n_push + NIN_W'(in_valid[i]);

      push_en = in_allowin && in_valid[0] && !flush && !bpu_flush && !reset;

      for (int i = 0; i < IN_WIDTH; i++) begin
         wr_en[i]  = push_en && in_valid[i];
         wr_idx[i] = tail_q + PTR_W'(i);
         wr_ent[i] = {in_data[i*ENTRY_W +: ENTRY_W], in_bd[i]};
      end

      // over-asked pops saturate at the occupancy rather than corrupting pointers
      pop_eff = (CNT_W'(out_pop_cnt) > count_q) ? POP_W'(count_q) : out_pop_cnt;
      r_idx   = head_q + PTR_W'(pop_eff);
      retain  = (count_q > CNT_W'(pop_eff)) && mem_q[r_idx][0];
   end

   always_comb begin
      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q;
      count_d = count_q - CNT_W'(pop_eff);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (bpu_flush) begin
         // keep only the delay slot that follows the redirecting branch
         if (retain) begin
            head_d  = r_idx;
            tail_d  = r_idx + PTR_W'(1);
            count_d = CNT_W'(1);
         end else begin
            head_d  = tail_q;
            count_d = '0;
         end
      end else if (push_en) begin
         tail_d  = tail_q + PTR_W'(n_push);
         count_d = count_q + CNT_W'(n_push) - CNT_W'(pop_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_WIDTH; i++)
         if (wr_en[i]) mem_q[wr_idx[i]] <= wr_ent[i];
   end

   for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_rd
      inst_queue_rd_lane #(
         .DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .PTR_W(PTR_W), .CNT_W(CNT_W), .LANE(g)
      ) u_lane (
         .mem   (mem_q),
         .head  (head_q),
         .count (count_q),
         .valid (out_valid[g]),
         .data  (out_data[g*ENTRY_W +: ENTRY_W]),
         .bd    (out_bd[g])
      );
   end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill/drain, wrap, simultaneous push/pop,
// both flush flavours and mid-operation reset.

module tb_inst_queue;
   localparam int EW = 96;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      in_valid;
   logic [2*EW-1:0] in_data;
   logic [1:0]      in_bd;
   logic            in_allowin;
   logic [1:0]      out_valid;
   logic [2*EW-1:0] out_data;
   logic [1:0]      out_bd;
   logic [1:0]      out_pop_cnt;
   logic            flush;
   logic            bpu_flush;
   logic [3:0]      count;

   int n_pass  = 0;
   int n_total = 0;

   inst_queue #(.DEPTH(8), .IN_WIDTH(2), .OUT_WIDTH(2), .ENTRY_W(EW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_bd(in_bd), .in_allowin(in_allowin),
      .out_valid(out_valid), .out_data(out_data), .out_bd(out_bd),
      .out_pop_cnt(out_pop_cnt), .flush(flush), .bpu_flush(bpu_flush), .count(count)
   );

   always #5 clk = ~clk;

   // decode must never ask for more entries than are shown valid
   always @(negedge clk)
      if (!reset && 32'(out_pop_cnt) > $countones(out_valid))
         $error("FAIL pop_cnt_legal observed=%0d allowed=%0d", out_pop_cnt, $countones(out_valid));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc(input logic [1:0] v, input logic [EW-1:0] d0, input logic [EW-1:0] d1,
                      input logic [1:0] bd, input logic [1:0] pop);
      in_valid    = v;
      in_data     = {d1, d0};
      in_bd       = bd;
      out_pop_cnt = pop;
      tick();
      in_valid    = 2'b00;
      out_pop_cnt = 2'd0;
   endtask

   logic [1:0] fill_bd [4];

   initial begin
      fill_bd = '{2'b00, 2'b10, 2'b01, 2'b11};
      reset = 1'b1; in_valid = '0; in_data = '0; in_bd = '0;
      out_pop_cnt = '0; flush = 1'b0; bpu_flush = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_count",   count, 0);
      chk("rst_valid",   out_valid, 0);
      chk("rst_allowin", in_allowin, 1);
      chk("rst_bd",      out_bd, 0);

      // fill 2,4,6,8 then a rejected push at full
      cyc(2'b11, 'h10, 'h14, fill_bd[0], 0);
      chk("fill_cnt2", count, 2);
      chk("fill_lat_data0", out_data[EW-1:0], 'h10);
      chk("fill_allow2", in_allowin, 1);
      cyc(2'b11, 'h18, 'h1c, fill_bd[1], 0);
      chk("fill_cnt4", count, 4);
      cyc(2'b11, 'h20, 'h24, fill_bd[2], 0);
      chk("fill_cnt6", count, 6);
      chk("fill_allow6", in_allowin, 1);
      cyc(2'b11, 'h28, 'h2c, fill_bd[3], 0);
      chk("fill_cnt8", count, 8);
      chk("fill_allow8", in_allowin, 0);
      cyc(2'b11, 'hdead, 'hbeef, 2'b11, 0);
      chk("full_reject_cnt", count, 8);

      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_d0", k), out_data[EW-1:0], EW'(32'h10 + 8*k));
         chk($sformatf("drain%0d_d1", k), out_data[2*EW-1:EW], EW'(32'h14 + 8*k));
         chk($sformatf("drain%0d_bd", k), out_bd, fill_bd[k]);
         cyc(2'b00, 0, 0, 0, 2);
         chk($sformatf("drain%0d_cnt", k), count, EW'(6 - 2*k));
      end
      chk("drain_valid", out_valid, 0);

      // walk head/tail to slot 6 using simultaneous push+pop
      cyc(2'b11, 'h1, 'h2, 0, 0);
      cyc(2'b11, 'h3, 'h4, 0, 2);
      chk("pp_cnt2", count, 2);
      cyc(2'b11, 'h5, 'h6, 0, 2);
      cyc(2'b00, 0, 0, 0, 2);
      chk("align_cnt0", count, 0);

      // wrap: slots 6,7,0,1
      cyc(2'b11, 'h100, 'h104, 0, 0);
      cyc(2'b11, 'h108, 'h10c, 0, 0);
      chk("wrap_cnt4", count, 4);
      chk("wrap_d0a", out_data[EW-1:0], 'h100);
      chk("wrap_d1a", out_data[2*EW-1:EW], 'h104);
      cyc(2'b00, 0, 0, 0, 2);
      chk("wrap_d0b", out_data[EW-1:0], 'h108);
      chk("wrap_d1b", out_data[2*EW-1:EW], 'h10c);
      cyc(2'b00, 0, 0, 0, 2);
      chk("wrap_cnt0", count, 0);

      // simultaneous push/pop at count 6, then odd count 7
      cyc(2'b11, 'h200, 'h204, 0, 0);
      cyc(2'b11, 'h208, 'h20c, 0, 0);
      cyc(2'b11, 'h210, 'h214, 0, 0);
      cyc(2'b11, 'h218, 'h21c, 0, 2);
      chk("sim_cnt6", count, 6);
      chk("sim_allow", in_allowin, 1);
      chk("sim_d0", out_data[EW-1:0], 'h208);
      cyc(2'b00, 0, 0, 0, 1);
      chk("pop1_cnt5", count, 5);
      cyc(2'b11, 'h220, 'h224, 0, 0);
      chk("odd_cnt7", count, 7);
      chk("odd_allow7", in_allowin, 0);
      cyc(2'b00, 0, 0, 0, 2);
      chk("pre_flush_cnt5", count, 5);

      // flush beats bpu_flush, push and pop
      flush = 1'b1; bpu_flush = 1'b1;
      in_valid = 2'b11; in_data = {96'h3ff, 96'h3fe}; out_pop_cnt = 2'd1;
      tick();
      flush = 1'b0; bpu_flush = 1'b0; in_valid = 2'b00; out_pop_cnt = 2'd0;
      chk("flush_cnt", count, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_allow", in_allowin, 1);

      // bpu_flush retaining the delay slot
      cyc(2'b11, 'h300, 'h304, 2'b10, 0);
      cyc(2'b11, 'h308, 'h30c, 2'b00, 0);
      chk("bds_cnt4", count, 4);
      bpu_flush = 1'b1;
      in_valid = 2'b11; in_data = {96'haaa, 96'hbbb}; in_bd = 2'b11; out_pop_cnt = 2'd1;
      tick();
      bpu_flush = 1'b0; in_valid = 2'b00; out_pop_cnt = 2'd0;
      chk("bds_cnt1", count, 1);
      chk("bds_valid", out_valid, 2'b01);
      chk("bds_bd", out_bd, 2'b01);
      chk("bds_d0", out_data[EW-1:0], 'h304);
      cyc(2'b00, 0, 0, 0, 1);
      chk("bds_drain", count, 0);

      // bpu_flush with no delay slot empties and drops the push
      cyc(2'b11, 'h400, 'h404, 2'b00, 0);
      chk("bnd_cnt2", count, 2);
      bpu_flush = 1'b1;
      in_valid = 2'b11; in_data = {96'hccc, 96'hddd}; in_bd = 2'b00;
      tick();
      bpu_flush = 1'b0; in_valid = 2'b00;
      chk("bnd_cnt0", count, 0);
      chk("bnd_allow", in_allowin, 1);
      chk("bnd_valid", out_valid, 0);
      cyc(2'b11, 'h500, 'h504, 2'b00, 0);
      chk("bnd_refill_d0", out_data[EW-1:0], 'h500);

      // reset mid-fill
      cyc(2'b11, 'h600, 'h604, 2'b11, 0);
      chk("mid_cnt4", count, 4);
      reset = 1'b1; in_valid = 2'b11; in_data = {96'heee, 96'hfff}; out_pop_cnt = 2'd1;
      tick();
      reset = 1'b0; in_valid = 2'b00; out_pop_cnt = 2'd0;
      chk("mrst_cnt", count, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_bd", out_bd, 0);
      cyc(2'b11, 'h700, 'h704, 2'b01, 0);
      chk("mrst_d0", out_data[EW-1:0], 'h700);
      chk("mrst_d1", out_data[2*EW-1:EW], 'h704);
      chk("mrst_bd2", out_bd, 2'b01);
      chk("mrst_cnt2", count, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised multi-entry instruction queue between the fetch and decode stages. It replaces the single `fs_to_ds_bus_r` holding register with a circular buffer. Fetch can push up to `IN_WIDTH` instructions per cycle and decode can pop up to `OUT_WIDTH` per cycle. On a branch-predictor flush it preserves a pending delay-slot instruction, the same way the single-entry decode stage does.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; must be a power of two and ≥ 2·max(`IN_WIDTH`,`OUT_WIDTH`).
- `IN_WIDTH`, 2, number of push lanes.
- `OUT_WIDTH`, 2, number of pop lanes.
- `ENTRY_W`, 96, payload width per entry (pc, inst, exception fields), opaque to the queue.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in `IN_WIDTH`: push lanes, prefix-contiguous from lane 0. A non-prefix pattern is illegal.
- `in_data` in `IN_WIDTH*ENTRY_W`: lane i occupies bits [i*ENTRY_W +: ENTRY_W].
- `in_bd` in `IN_WIDTH`: per-lane delay-slot flag.
- `in_allowin` out 1: queue can take a full `IN_WIDTH` group this cycle.
- `out_valid` out `OUT_WIDTH`: prefix-contiguous; lane 0 is the oldest entry.
- `out_data` out `OUT_WIDTH*ENTRY_W`: payload of the oldest entries.
- `out_bd` out `OUT_WIDTH`: delay-slot flag of each output lane.
- `out_pop_cnt` in clog2(`OUT_WIDTH`+1): entries consumed this cycle. Must be ≤ popcount(`out_valid`).
- `flush` in 1: exception/eret pipeline flush.
- `bpu_flush` in 1: branch-mispredict redirect.
- `count` out clog2(`DEPTH`+1): current occupancy.

## Operation
- Storage: `DEPTH` entries of {payload, bd}. `head` and `tail` pointers are log2(`DEPTH`) bits wide and wrap modulo `DEPTH`. `count` is kept explicitly so full and empty are unambiguous.
- `in_allowin` = (`DEPTH` − `count`) ≥ `IN_WIDTH`. It is computed from the registered `count` only; pops in the same cycle are not credited.
- Push:
  - Accepted when `in_allowin` && `in_valid[0]` && !`flush` && !`bpu_flush`.
  - n_push = popcount(`in_valid`).
  - Lane i is written to (`tail`+i) mod `DEPTH`; then `tail` += n_push.
  - Pushes are all-or-nothing per group.
- Pop:
  - `out_valid[i]` = (`count` > i).
  - `out_data`/`out_bd` lane i = entry (`head`+i) mod `DEPTH`.
  - `head` += `out_pop_cnt`.
- Normal update: `count` ← `count` + n_push − `out_pop_cnt`. Simultaneous push and pop are allowed, including at full (only when `in_allowin` holds) and at empty (push only).
- `flush` has the highest priority after `reset`:
  - `head` ← `tail` ← 0, `count` ← 0.
  - Pushes and pops in that cycle are discarded.
- `bpu_flush` (when `flush` is low): the pushes of that cycle are discarded. Let r = the entry at (`head`+`out_pop_cnt`), i.e. the oldest entry surviving this cycle's pop.
  - If `count` > `out_pop_cnt` and r.bd = 1, r is retained: `head` ← `head`+`out_pop_cnt`, `tail` ← `head`+`out_pop_cnt`+1, `count` ← 1.
  - Otherwise the queue empties: `head` ← `tail`, `count` ← 0.
- Payload of invalid lanes is don't-care. Storage RAM needs no reset; only pointers and `count` are reset.

## Timing
- Reset values: `count`=0, `head`=`tail`=0, `out_valid`=0, `in_allowin`=1, `out_bd`=0.
- Latency: an entry pushed in cycle t is visible on `out_valid` in cycle t+1. There is no bypass.
- Outputs are combinational from registered state. `out_valid`/`out_data`/`out_bd` do not depend on `out_pop_cnt`, `in_valid`, `flush` or `bpu_flush` in the same cycle.
- Flush and bpu_flush take effect at the clock edge; the next cycle shows the post-flush state.
- `reset` asserted mid-operation behaves like `flush` and also clears `out_bd`. It overrides all other inputs.
- Pointer wrap: `tail`+i and `head`+i use modulo-`DEPTH` arithmetic. At `DEPTH`=8, an entry pushed at `tail`=7 with 2 lanes writes slots 7 and 0.
- An illegal `out_pop_cnt` > valid count is a bench assertion failure. The RTL may saturate but is not required to.

## Test plan
- Fill/drain: push 2 per cycle for 4 cycles with `out_pop_cnt`=0.
  - `count` goes 2,4,6,8.
  - `in_allowin` drops to 0 in the cycle `count`=8 (it is already 0 when `count`=7, should an odd count arise).
  - Then pop 2 per cycle: FIFO order is preserved and `count` reaches 0 after 4 cycles.
- Wrap-around: with `head`=`tail`=6, push pcs 0x100/0x104, then 0x108/0x10c.
  - Entries land in slots 6,7,0,1.
  - Pops return 0x100,0x104,0x108,0x10c in order.
- Simultaneous push/pop at `count`=6: push 2 and pop 2 in the same cycle.
  - `count` stays 6.
  - `in_allowin` stays 1 next cycle.
- bpu_flush keeping a delay slot: queue holds [branch, ds(bd=1), x, y]; `out_pop_cnt`=1 with `bpu_flush`=1.
  - Next cycle `count`=1, `out_valid`=01, `out_bd[0]`=1, `out_data` lane 0 = ds.
- bpu_flush without a delay slot: queue holds [a(bd=0), b]; `bpu_flush`=1 with a push of 2.
  - Next cycle `count`=0.
  - Push discarded, `in_allowin`=1.
- flush priority: `flush`=1 together with `bpu_flush`=1, a push of 2 and a pop of 1 at `count`=5.
  - Next cycle `count`=0, `out_valid`=0.
  - Applying `reset` mid-fill gives the same result.
